m_pipeline_stage1_if: RTL and testbench
=======================================

# m_pipeline_stage1_if

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID stage. It owns the program counter and drives a req/ack instruction-memory port with variable latency. It loads the IF/ID pipeline register (instruction, PC+4, valid) consumed by ID. It absorbs ID stalls with a one-entry buffer and squashes wrong-path fetches on branch redirect.

## Interface
- N, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, PC increment per instruction
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hazard unit: hold IF/ID register and PC
- redirect  in  1  taken branch/jump resolved; flush IF/ID, refetch from redirect_pc
- redirect_pc  in  N  target address, sampled when redirect=1
- imem_req  out  1  fetch request
- imem_addr  out  N  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  data valid this cycle; transfer completes at this edge (same-cycle ack allowed)
- imem_rdata  in  N  instruction word, valid when imem_ack=1
- instruction  out  N  IF/ID: instruction to ID
- pc_out  out  N  IF/ID: address of that instruction + PC_STEP
- valid_out  out  1  IF/ID: entry holds a real instruction

## Operation
- Registers: pc (address of current/outstanding fetch), target_r, buf_instr, buf_pc, state, IF/ID {instruction, pc_out, valid_out}.
- States: FETCH (imem_req=1, imem_addr=pc), DRAIN (imem_req=1, imem_addr=pc, data will be discarded), BUFFER (imem_req=0, one fetched word held).
- FETCH, redirect & ack: drop data, pc<=redirect_pc, stay FETCH.
- FETCH, redirect & !ack: target_r<=redirect_pc, go DRAIN (outstanding request must complete at unchanged address).
- FETCH, !redirect & ack & !stall: IF/ID<={imem_rdata, pc+PC_STEP, 1}; pc<=pc+PC_STEP.
- FETCH, !redirect & ack & stall: buf<={imem_rdata, pc+PC_STEP}; pc<=pc+PC_STEP; go BUFFER.
- FETCH, no ack: stay.
- DRAIN, ack: discard data; pc<=redirect? redirect_pc : target_r; go FETCH. DRAIN, redirect & !ack: target_r<=redirect_pc.
- BUFFER, redirect: discard buffer, pc<=redirect_pc, go FETCH. BUFFER, !stall: IF/ID<=buf, go FETCH. BUFFER, stall: stay.
- IF/ID priority: redirect (bubble) > stall (hold) > load > bubble (FETCH/DRAIN with no usable data and !stall).
- Bubble = instruction 32'h0000_0000 (sll $0,$0,0), pc_out 0, valid_out 0.
- PC arithmetic modulo 2^N; 32'hFFFF_FFFC + 4 wraps to 0, no flag.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, instruction=0, pc_out=0, valid_out=0, target_r/buf=0. imem_req=1 on first cycle after reset release.
- imem_req/imem_addr combinational from state and pc only (no input paths).
- Zero-wait memory (ack same cycle as req): one instruction per cycle; IF/ID valid on the edge of ack.
- Reset mid-request abandons the transaction; memory must tolerate req dropping without ack.
- stall and redirect in same cycle: redirect wins.
- Throughput after redirect: first target instruction reaches IF/ID at the edge of its ack. No wrong-path instruction ever has valid_out=1.

## Structure
- Shared pipeline package: state enum {FETCH, DRAIN, BUFFER}, NOP_INSTR constant, PC_STEP default.
- Single module, no sub-modules. The buffer is one entry inline. ID-stage register conventions apply unchanged to the IF/ID outputs.

## Test plan
- Reset release, zero-wait memory returning addr-tagged words -> addresses 0,4,8 on consecutive cycles; pc_out 4,8,12; valid_out=1 from first ack.
- Memory with 3-cycle latency -> imem_addr stable during wait; valid_out=0 for 2 bubbles, then instruction loaded.
- stall asserted for 3 cycles on an ack at pc=8 -> state BUFFER, imem_req=0, IF/ID holds pc_out 8. On release, instruction@8 appears with pc_out 12; fetch resumes at 12.
- redirect to 0x100 while 3-cycle request to 0x10 outstanding -> DRAIN, addr stays 0x10, data dropped. Next request is 0x100, no valid_out for 0x10.
- redirect and stall together while in BUFFER -> buffer discarded, IF/ID bubble, next fetch 0x100.
- Async reset asserted mid-wait -> outputs zero immediately (before the clock edge); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/m_pipeline_stage1_if_pkg.sv
// Shared pipeline definitions for the MIPS front end.
// IF-stage state encoding and IF/ID bubble constants.
package m_pipeline_stage1_if_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    BUFFER = 2'd2
  } if_state_t;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_STEP_DEF = 4;

endpackage

// File: rtl/m_pipeline_stage1_if.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack port,
// loads IF/ID, absorbs ID stalls with a one-entry buffer, squashes on redirect.
module m_pipeline_stage1_if
  import m_pipeline_stage1_if_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int          PC_STEP  = PC_STEP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] instruction,
  output logic [N-1:0] pc_out,
  output logic         valid_out
);

  if_state_t    state;
  logic [N-1:0] pc;
  logic [N-1:0] target_r;
  logic [N-1:0] buf_instr;
  logic [N-1:0] buf_pc;
  logic [N-1:0] pc_inc;

  logic do_flush;
  logic do_hold;
  logic do_load_f;
  logic do_load_b;

  assign pc_inc    = pc + N'(PC_STEP);
  assign imem_req  = (state != BUFFER);
  assign imem_addr = pc;

  // mutually exclusive IF/ID update selects
  always_comb begin
    do_flush  = redirect;
    do_hold   = !redirect && stall;
    do_load_f = !redirect && !stall &&
                (state == FETCH) && imem_ack;
    do_load_b = !redirect && !stall &&
                (state == BUFFER);
  end

  // PC, buffer and fetch state sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      target_r  <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              pc <= redirect_pc;
            end else begin
              target_r <= redirect_pc;
              state    <= DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc_inc;
            if (stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc_inc;
              state     <= BUFFER;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= redirect ? redirect_pc : target_r;
            state <= FETCH;
          end else if (redirect) begin
            target_r <= redirect_pc;
          end
        end
        BUFFER: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush > hold > load > bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= N'(NOP_INSTR);
      pc_out      <= '0;
      valid_out   <= 1'b0;
    end else begin
      unique case (1'b1)
        do_flush: begin
          instruction <= N'(NOP_INSTR);
          pc_out      <= '0;
          valid_out   <= 1'b0;
        end
        do_hold: ;
        do_load_f: begin
          instruction <= imem_rdata;
          pc_out      <= pc_inc;
          valid_out   <= 1'b1;
        end
        do_load_b: begin
          instruction <= buf_instr;
          pc_out      <= buf_pc;
          valid_out   <= 1'b1;
        end
        default: begin
          instruction <= N'(NOP_INSTR);
          pc_out      <= '0;
          valid_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_pipeline_stage1_if.sv
// Directed bench for the IF stage.
// Memory returns address-tagged words: word(a) = 32'hC000_0000 ^ a.
module tb_m_pipeline_stage1_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid_out;

  int n_chk  = 0;
  int n_pass = 0;

  m_pipeline_stage1_if dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .pc_out(pc_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic chk(input string t,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", t, got, exp);
  endtask

  // one cycle: drive at negedge, sample 1ns after posedge
  task automatic step(input logic a, input logic s,
                      input logic r, input logic [31:0] rp);
    @(negedge clk);
    imem_ack    = a;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
    imem_rdata  = a ? tag(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string t, input logic [31:0] ei,
                      input logic [31:0] ep, input logic ev);
    chk({t, ".instr"}, instruction, ei);
    chk({t, ".pc"}, pc_out, ep);
    chk({t, ".valid"}, {31'd0, valid_out}, {31'd0, ev});
  endtask

  task automatic fe(input string t, input logic er,
                    input logic [31:0] ea);
    chk({t, ".req"}, {31'd0, imem_req}, {31'd0, er});
    chk({t, ".addr"}, imem_addr, ea);
  endtask

  initial begin
    reset = 1'b1; stall = 0; redirect = 0;
    redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    #2;
    ifid("rst", 0, 0, 0);
    fe("rst", 1, 0);
    @(negedge clk); reset = 1'b0;

    // zero-wait streaming
    step(1, 0, 0, 0); ifid("zw0", tag(0), 4, 1);  fe("zw0", 1, 4);
    step(1, 0, 0, 0); ifid("zw1", tag(4), 8, 1);  fe("zw1", 1, 8);
    step(1, 0, 0, 0); ifid("zw2", tag(8), 12, 1); fe("zw2", 1, 12);

    // 3-cycle latency
    step(0, 0, 0, 0); ifid("lat0", 0, 0, 0); fe("lat0", 1, 12);
    step(0, 0, 0, 0); ifid("lat1", 0, 0, 0); fe("lat1", 1, 12);
    step(1, 0, 0, 0); ifid("lat2", tag(12), 16, 1); fe("lat2", 1, 16);

    // stall on ack -> BUFFER
    step(1, 1, 0, 0); ifid("st0", tag(12), 16, 1); fe("st0", 0, 20);
    step(0, 1, 0, 0); ifid("st1", tag(12), 16, 1); fe("st1", 0, 20);
    step(0, 1, 0, 0); ifid("st2", tag(12), 16, 1); fe("st2", 0, 20);
    step(0, 0, 0, 0); ifid("st3", tag(16), 20, 1); fe("st3", 1, 20);

    // redirect while request outstanding -> DRAIN
    step(0, 0, 0, 0);     ifid("dr0", 0, 0, 0); fe("dr0", 1, 20);
    step(0, 0, 1, 'h100); ifid("dr1", 0, 0, 0); fe("dr1", 1, 20);
    step(0, 0, 0, 0);     ifid("dr2", 0, 0, 0); fe("dr2", 1, 20);
    step(1, 0, 0, 0);     ifid("dr3", 0, 0, 0); fe("dr3", 1, 'h100);
    step(1, 0, 0, 0);
    ifid("dr4", tag('h100), 'h104, 1); fe("dr4", 1, 'h104);

    // redirect+stall in BUFFER
    step(1, 1, 0, 0);
    ifid("bf0", tag('h100), 'h104, 1); fe("bf0", 0, 'h108);
    step(0, 1, 1, 'h200); ifid("bf1", 0, 0, 0); fe("bf1", 1, 'h200);
    step(1, 0, 0, 0);
    ifid("bf2", tag('h200), 'h204, 1); fe("bf2", 1, 'h204);

    // redirect with same-cycle ack, then PC wrap
    step(1, 0, 1, 32'hFFFF_FFFC);
    ifid("wr0", 0, 0, 0); fe("wr0", 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    ifid("wr1", tag(32'hFFFF_FFFC), 0, 1); fe("wr1", 1, 0);

    // second redirect while draining retargets
    step(0, 0, 1, 'h300); ifid("rt0", 0, 0, 0); fe("rt0", 1, 0);
    step(0, 0, 1, 'h400); ifid("rt1", 0, 0, 0); fe("rt1", 1, 0);
    step(1, 0, 0, 0);     ifid("rt2", 0, 0, 0); fe("rt2", 1, 'h400);
    step(1, 0, 0, 0);
    ifid("rt3", tag('h400), 'h404, 1); fe("rt3", 1, 'h404);

    // async reset mid-wait, IF/ID held valid by stall
    step(0, 1, 0, 0);
    ifid("ar0", tag('h400), 'h404, 1); fe("ar0", 1, 'h404);
    @(negedge clk);
    stall = 0; imem_ack = 0;
    reset = 1'b1;
    #1;
    ifid("ar1", 0, 0, 0); fe("ar1", 1, 0);
    @(negedge clk); reset = 1'b0;
    step(1, 0, 0, 0); ifid("ar2", tag(0), 4, 1); fe("ar2", 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
